// File: rtl/src_encoder_if.sv
// Bus-source arbitration bundle between the request lines and the source encoder.
// master drives requests/done; slave (the encoder) drives the registered grant outputs.
interface src_encoder_if;
    logic [15:0] req;
    logic        done;
    logic [3:0]  src_sel;
    logic [15:0] grant;
    logic        valid;
    logic        timeout;

    modport master (
        output req,
        output done,
        input  src_sel,
        input  grant,
        input  valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output src_sel,
        output grant,
        output valid,
        output timeout
    );
endinterface

// File: rtl/src_encoder.sv
// Round-robin 16-to-4 source encoder with held grant and registered outputs.
// Optional forced release after MAX_HOLD cycles: define SRC_ENCODER_HOLD_TIMEOUT_EN.
module src_encoder #(
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    src_encoder_if.slave bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  ptr_reg, ptr_next;
    logic [3:0]  src_sel_reg, src_sel_next;
    logic [15:0] grant_reg, grant_next;
    logic        valid_reg, valid_next;
    logic        timeout_reg, timeout_next;

    logic [3:0]  search_base;
    logic [15:0] req_rot;
    logic        found;
    logic [3:0]  offset;
    logic [3:0]  winner;
    logic        force_release;
    logic        release_now;
    logic        load;

    if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
        $error("src_encoder: MAX_HOLD must be in 2..256");
    end

    // On a release the search starts just past the current owner, so it is considered last.
    assign search_base = (state_reg == GRANT) ? src_sel_reg + 4'd1 : ptr_reg;

    for (genvar gi = 0; gi < 16; gi++) begin : g_rot
        assign req_rot[gi] = bus.req[search_base + 4'(gi)];
    end

    always_comb begin
        found  = 1'b0;
        offset = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (req_rot[i]) begin
                found  = 1'b1;
                offset = 4'(i);
            end
        end
    end

    assign winner = search_base + offset;

`ifdef SRC_ENCODER_HOLD_TIMEOUT_EN
    logic [7:0] cnt_reg, cnt_next;

    assign force_release = (state_reg == GRANT) && (cnt_reg == 8'(MAX_HOLD - 1));

    always_comb begin
        cnt_next = 8'd0;
        if (load) begin
            cnt_next = 8'd0;
        end else if (state_reg == GRANT) begin
            cnt_next = cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= 8'd0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end
`else
    assign force_release = 1'b0;
`endif

    assign release_now = bus.done || !bus.req[src_sel_reg] || force_release;

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        src_sel_next = src_sel_reg;
        grant_next   = grant_reg;
        valid_next   = valid_reg;
        timeout_next = 1'b0;
        load         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (found) begin
                    load = 1'b1;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_next     = src_sel_reg + 4'd1;
                    timeout_next = force_release;
                    if (found) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                        valid_next = 1'b0;
                        grant_next = 16'h0000;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
                grant_next = 16'h0000;
            end
        endcase

        if (load) begin
            state_next   = GRANT;
            src_sel_next = winner;
            grant_next   = 16'h0001 << winner;
            valid_next   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            ptr_reg     <= 4'd0;
            src_sel_reg <= 4'd0;
            grant_reg   <= 16'h0000;
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            src_sel_reg <= src_sel_next;
            grant_reg   <= grant_next;
            valid_reg   <= valid_next;
            timeout_reg <= timeout_next;
        end
    end

    assign bus.src_sel = src_sel_reg;
    assign bus.grant   = grant_reg;
    assign bus.valid   = valid_reg;
    assign bus.timeout = timeout_reg;

endmodule
